// File: rtl/audio_mix_scheduler.sv
// Round-robin req/ack gather of stereo samples from NUM_SRC sources, saturating mix to the DAC.
// Optional master attenuation is enabled with the AUDIO_MIX_VOLUME_EN macro.
module audio_mix_scheduler #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       advance,
  input  logic [NUM_SRC-1:0]         src_enable,
  output logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC-1:0]         src_ack,
  input  logic [NUM_SRC*WIDTH-1:0]   src_left,
  input  logic [NUM_SRC*WIDTH-1:0]   src_right,
  input  logic                       clear_stats,
`ifdef AUDIO_MIX_VOLUME_EN
  input  logic [2:0]                 master_atten,
`endif
  output logic [WIDTH-1:0]           dac_left,
  output logic [WIDTH-1:0]           dac_right,
  output logic                       busy,
  output logic [NUM_SRC-1:0]         missed,
  output logic [15:0]                underrun_count
);

  localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned AW = WIDTH + 3;
  localparam logic [WIDTH-1:0]      SILENCE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0]  MAX_V   = {4'b0000, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]  MIN_V   = {4'b1111, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]            TMAX    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StAcc, StDone} state_e;

  state_e                   r_state;
  logic [IW-1:0]            r_idx;
  logic [NUM_SRC-1:0]       r_snap;
  logic [NUM_SRC-1:0]       r_req;
  logic [7:0]               r_tcnt;
  logic signed [WIDTH-1:0]  r_smp_l, r_smp_r;
  logic signed [AW-1:0]     r_acc_l, r_acc_r;
  logic [WIDTH-1:0]         r_pend_l, r_pend_r;
  logic [WIDTH-1:0]         r_dac_l, r_dac_r;
  logic                     r_busy;
  logic [NUM_SRC-1:0]       r_missed;
  logic [15:0]              r_uc;

  logic                     w_en, w_ack, w_last, w_tmo, w_under;
  logic [NUM_SRC-1:0]       w_onehot;
  logic [WIDTH-1:0]         w_sl, w_sr;
  logic signed [WIDTH-1:0]  w_sat_l, w_sat_r, w_att_l, w_att_r;
  logic [WIDTH-1:0]         w_mix_l, w_mix_r;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] a);
    if (a > MAX_V) return MAX_V[WIDTH-1:0];
    if (a < MIN_V) return MIN_V[WIDTH-1:0];
    return a[WIDTH-1:0];
  endfunction

  always_comb begin
    w_en     = 1'b0;
    w_ack    = 1'b0;
    w_sl     = '0;
    w_sr     = '0;
    w_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_idx == IW'(i)) begin
        w_en        = r_snap[i];
        w_ack       = src_ack[i];
        w_sl        = src_left[i*WIDTH +: WIDTH];
        w_sr        = src_right[i*WIDTH +: WIDTH];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_last  = (r_idx == IW'(NUM_SRC - 1));
  assign w_under = advance && r_busy;
  // An underrun restart on the same edge aborts the pending timeout.
  assign w_tmo   = !advance && (r_state == StReq) && (r_req != '0) && !w_ack && (r_tcnt == TMAX);

  assign w_sat_l = sat(r_acc_l);
  assign w_sat_r = sat(r_acc_r);
`ifdef AUDIO_MIX_VOLUME_EN
  assign w_att_l = w_sat_l >>> master_atten;
  assign w_att_r = w_sat_r >>> master_atten;
`else
  assign w_att_l = w_sat_l;
  assign w_att_r = w_sat_r;
`endif
  assign w_mix_l = {~w_att_l[WIDTH-1], w_att_l[WIDTH-2:0]};
  assign w_mix_r = {~w_att_r[WIDTH-1], w_att_r[WIDTH-2:0]};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_snap   <= '0;
      r_req    <= '0;
      r_tcnt   <= '0;
      r_smp_l  <= '0;
      r_smp_r  <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_pend_l <= SILENCE;
      r_pend_r <= SILENCE;
      r_dac_l  <= SILENCE;
      r_dac_r  <= SILENCE;
      r_busy   <= 1'b0;
      r_missed <= '0;
      r_uc     <= '0;
    end else begin
      r_missed <= (clear_stats ? '0 : r_missed) | (w_tmo ? w_onehot : '0);
      if (w_under) begin
        r_uc <= clear_stats ? 16'd1 : ((r_uc == 16'hFFFF) ? r_uc : r_uc + 16'd1);
      end else if (clear_stats) begin
        r_uc <= '0;
      end

      if (advance) begin
        r_dac_l <= r_busy ? SILENCE : r_pend_l;
        r_dac_r <= r_busy ? SILENCE : r_pend_r;
        if (r_state == StDone) begin
          r_pend_l <= w_mix_l;
          r_pend_r <= w_mix_r;
        end
        r_acc_l <= '0;
        r_acc_r <= '0;
        r_snap  <= src_enable;
        r_idx   <= '0;
        r_req   <= '0;
        r_tcnt  <= '0;
        r_busy  <= 1'b1;
        r_state <= StReq;
      end else begin
        unique case (r_state)
          StIdle: ;
          StReq: begin
            // A request always starts with one cycle of req low, so restarts show a gap.
            if (r_req == '0) begin
              if (w_en) begin
                r_req  <= w_onehot;
                r_tcnt <= '0;
              end else if (w_last) begin
                r_busy  <= 1'b0;
                r_state <= StDone;
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end else if (w_ack) begin
              r_smp_l <= {~w_sl[WIDTH-1], w_sl[WIDTH-2:0]};
              r_smp_r <= {~w_sr[WIDTH-1], w_sr[WIDTH-2:0]};
              r_req   <= '0;
              r_state <= StAcc;
            end else if (r_tcnt == TMAX) begin
              r_smp_l <= '0;
              r_smp_r <= '0;
              r_req   <= '0;
              r_state <= StAcc;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
          StAcc: begin
            r_acc_l <= r_acc_l + {{3{r_smp_l[WIDTH-1]}}, r_smp_l};
            r_acc_r <= r_acc_r + {{3{r_smp_r[WIDTH-1]}}, r_smp_r};
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= StDone;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= StReq;
            end
          end
          StDone: begin
            r_pend_l <= w_mix_l;
            r_pend_r <= w_mix_r;
            r_state  <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign src_req        = r_req;
  assign dac_left       = r_dac_l;
  assign dac_right      = r_dac_r;
  assign busy           = r_busy;
  assign missed         = r_missed;
  assign underrun_count = r_uc;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Scoreboard bench for audio_mix_scheduler: behavioural sources, reference mix model, DAC monitor.
module tb_audio_mix_scheduler;
  localparam int NS  = 4;
  localparam int W   = 24;
  localparam int TMO = 64;
  localparam int SIL = 32'h800000;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              advance = 1'b0;
  logic              clear_stats = 1'b0;
  logic [NS-1:0]     src_enable = '0;
  logic [NS-1:0]     src_req;
  logic [NS-1:0]     src_ack = '0;
  logic [NS*W-1:0]   src_left = '0;
  logic [NS*W-1:0]   src_right = '0;
  logic [W-1:0]      dac_left, dac_right;
  logic              busy;
  logic [NS-1:0]     missed;
  logic [15:0]       underrun_count;
`ifdef AUDIO_MIX_VOLUME_EN
  logic [2:0]        master_atten = 3'd0;
`endif

  audio_mix_scheduler #(.NUM_SRC(NS), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .CLOCK_50       (clk),
    .reset          (rst),
    .advance        (advance),
    .src_enable     (src_enable),
    .src_req        (src_req),
    .src_ack        (src_ack),
    .src_left       (src_left),
    .src_right      (src_right),
    .clear_stats    (clear_stats),
`ifdef AUDIO_MIX_VOLUME_EN
    .master_atten   (master_atten),
`endif
    .dac_left       (dac_left),
    .dac_right      (dac_right),
    .busy           (busy),
    .missed         (missed),
    .underrun_count (underrun_count)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] model_pend;
  logic [2*W-1:0] mon_e;
  logic [NS-1:0]  exp_missed = '0;
  int             exp_uc = 0;
  int             dly[NS];
  int             rcnt[NS];
  int             run_len[NS];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference mix: offset-binary to signed, integer sum, clamp, back to offset-binary.
  function automatic logic [2*W-1:0] mix(input logic [NS-1:0] en, input logic [NS*W-1:0] l,
                                         input logic [NS*W-1:0] r);
    longint sl = 0;
    longint sr = 0;
    longint lo = -longint'(SIL);
    longint hi = longint'(SIL) - 1;
    logic [63:0] tl, tr;
    for (int i = 0; i < NS; i++) begin
      if (en[i] && dly[i] <= TMO) begin
        sl += longint'(l[i*W +: W]) - SIL;
        sr += longint'(r[i*W +: W]) - SIL;
      end
    end
    if (sl > hi) sl = hi;
    if (sl < lo) sl = lo;
    if (sr > hi) sr = hi;
    if (sr < lo) sr = lo;
    tl = 64'(sl + SIL);
    tr = 64'(sr + SIL);
    return {tl[W-1:0], tr[W-1:0]};
  endfunction

  // Monitor: every advance edge presents a frame on the DAC.
  initial begin
    forever begin
      @(posedge clk);
      if (advance && !rst) begin
        #1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dac_unexpected: got %0h/%0h with no expected frame", dac_left, dac_right);
        end else begin
          mon_e = exp_q.pop_front();
          check("dac_left", dac_left, mon_e[2*W-1:W]);
          check("dac_right", dac_right, mon_e[W-1:0]);
        end
      end
    end
  end

  // Sources: ack dly cycles into a request; random noise on non-requested ack bits.
  initial begin
    for (int i = 0; i < NS; i++) begin
      rcnt[i] = 0;
      run_len[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (src_req[i]) rcnt[i]++;
        else begin
          if (rcnt[i] > 0) run_len[i] = rcnt[i];
          rcnt[i] = 0;
        end
        src_ack[i] = src_req[i] ? (rcnt[i] == dly[i]) : ($urandom_range(3) == 0);
      end
    end
  end

  task automatic pulse_adv();
    @(negedge clk);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL gather_timeout: busy=%0b after %0d cycles, expected 0", busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic [NS-1:0] en, input logic [NS*W-1:0] l,
                       input logic [NS*W-1:0] r);
    src_enable = en;
    src_left   = l;
    src_right  = r;
    exp_q.push_back(model_pend);
    pulse_adv();
    check("busy_start", busy, 1);
    wait_idle();
    model_pend = mix(en, l, r);
    for (int i = 0; i < NS; i++) if (en[i] && dly[i] > TMO) exp_missed[i] = 1'b1;
    check("missed", missed, exp_missed);
    check("underrun_count", underrun_count, exp_uc);
  endtask

  function automatic logic [NS*W-1:0] rnd_bus();
    logic [NS*W-1:0] b;
    for (int i = 0; i < NS; i++) b[i*W +: W] = W'($urandom);
    return b;
  endfunction

  initial begin
    logic [NS*W-1:0] l, r;
    model_pend = {W'(SIL), W'(SIL)};
    for (int i = 0; i < NS; i++) dly[i] = 2;

    repeat (3) @(negedge clk);
    check("rst_dac_left", dac_left, SIL);
    check("rst_dac_right", dac_right, SIL);
    check("rst_src_req", src_req, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed, 0);
    check("rst_underrun", underrun_count, 0);
    rst = 1'b0;
    @(negedge clk);

    frame('0, rnd_bus(), rnd_bus());

    l = rnd_bus();
    l[0*W +: W] = 24'h900000;
    l[1*W +: W] = 24'h900000;
    frame(4'b0011, l, rnd_bus());

    for (int i = 0; i < NS; i++) l[i*W +: W] = 24'hF00000;
    frame(4'b1111, l, rnd_bus());
    for (int i = 0; i < NS; i++) l[i*W +: W] = 24'h100000;
    frame(4'b1111, l, rnd_bus());

    // Source 2 never answers.
    dly[2] = NEVER;
    run_len[2] = 0;
    frame(4'b1111, rnd_bus(), rnd_bus());
    check("timeout_req_len", run_len[2], TMO);
    dly[2] = 2;
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    exp_missed = '0;
    check("missed_cleared", missed, 0);

    // Ack on the last allowed cycle is accepted, one later is not.
    dly[0] = TMO;
    dly[1] = TMO + 1;
    frame(4'b0011, rnd_bus(), rnd_bus());
    for (int i = 0; i < NS; i++) dly[i] = 10;

    // Underrun: re-advance 20 cycles into a slow gather.
    l = rnd_bus();
    r = rnd_bus();
    src_enable = 4'b1111;
    src_left   = l;
    src_right  = r;
    exp_q.push_back(model_pend);
    pulse_adv();
    repeat (18) @(negedge clk);
    check("busy_mid_gather", busy, 1);
    exp_q.push_back({W'(SIL), W'(SIL)});
    exp_uc = 1;
    pulse_adv();
    check("req_gap", src_req, 0);
    @(negedge clk);
    check("req_restart", src_req, 1);
    wait_idle();
    model_pend = mix(4'b1111, l, r);
    check("underrun_count", underrun_count, exp_uc);
    check("missed", missed, exp_missed);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NS; i++) dly[i] = ($urandom_range(7) == 0) ? NEVER : $urandom_range(1, 6);
      frame(NS'($urandom), rnd_bus(), rnd_bus());
    end

    // Asynchronous reset mid-gather.
    for (int i = 0; i < NS; i++) dly[i] = 8;
    src_enable = 4'b1111;
    exp_q.push_back(model_pend);
    pulse_adv();
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_src_req", src_req, 0);
    check("arst_dac_left", dac_left, SIL);
    check("arst_missed", missed, 0);
    check("arst_underrun", underrun_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_missed = '0;
    exp_uc = 0;
    model_pend = {W'(SIL), W'(SIL)};
    @(negedge clk);

    dly[0] = 3;
    l = rnd_bus();
    l[0*W +: W] = 24'hC00000;
    frame(4'b0001, l, rnd_bus());
    frame('0, rnd_bus(), rnd_bus());
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_mix_scheduler.md
Name: audio_mix_scheduler

Overview:
- Shares the single CODEC DAC sample slot between NUM_SRC sample producers, for example a music streamer and sound-effect voices.
- Each advance pulse from the audio driver does two things:
  - presents the previously mixed stereo frame on dac_left/dac_right;
  - starts a round-robin req/ack gather of the next frame from every enabled source, then sums the samples with saturation.
- Sits between the game-side audio sources and the audio driver's dac_left/dac_right/advance ports.

Parameters:
- NUM_SRC, 4, number of requesting sources (1..8).
- WIDTH, 24, sample width in bits, unsigned offset-binary PCM.
- TIMEOUT, 64, cycles a source may hold off ack before it is skipped (2..255).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- advance  input  1  one-cycle sample strobe from the audio driver.
- src_enable  input  NUM_SRC  per-source enable, sampled when a gather starts.
- src_req  output  NUM_SRC  one-hot request to the source currently being serviced.
- src_ack  input  NUM_SRC  source's one-cycle data-valid response.
- src_left  input  NUM_SRC*WIDTH  packed left samples; source i occupies [i*WIDTH +: WIDTH].
- src_right  input  NUM_SRC*WIDTH  packed right samples, same packing.
- clear_stats  input  1  synchronous clear of missed and underrun_count.
- dac_left  output  WIDTH  mixed left sample to the driver.
- dac_right  output  WIDTH  mixed right sample to the driver.
- busy  output  1  high while a gather is in progress.
- missed  output  NUM_SRC  sticky per-source timeout flags.
- underrun_count  output  16  saturating count of advances that arrived mid-gather.

Behaviour:
- Reset values:
  - dac_left = dac_right = 2^(WIDTH-1) (0x800000, silence).
  - Pending mix registers = silence.
  - src_req = 0, busy = 0, missed = 0, underrun_count = 0.
  - State = IDLE.
- States: IDLE, REQ, ACC, DONE.
- IDLE/DONE, on advance = 1:
  - dac_* <= pending mix.
  - Accumulators <= 0; src_enable snapshot taken; index <= 0.
  - Go to REQ.
  - The driver captures the old dac_* on that same edge. Net latency is exactly one sample period.
- REQ:
  - If snapshot[index] = 0: no req is driven; index advances next cycle, 1 cycle per skipped source.
  - Otherwise src_req[index] = 1 and a timeout counter runs.
  - On the first cycle src_ack[index] = 1: latch src_left/src_right slice, go to ACC, src_req drops next cycle.
  - If TIMEOUT cycles pass without ack: drop req, set missed[index], the source contributes 0, go to ACC.
  - src_ack on any non-requested bit is ignored.
- ACC:
  - Convert each channel to signed by inverting the MSB.
  - Add into an accumulator of WIDTH+3 bits.
  - index++. If index = NUM_SRC go to DONE, else go to REQ.
- DONE:
  - Saturate the accumulator to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Invert the MSB back to offset binary and store in the pending registers.
  - Clear busy and go to IDLE.
- busy = 1 in REQ and ACC.
- Underrun (advance while busy):
  - dac_* <= silence.
  - underrun_count++, saturating at 0xFFFF.
  - The gather restarts from index 0 on the same edge; src_req is deasserted for one cycle.
  - missed bits already set are kept.
- No enabled sources: the gather takes NUM_SRC cycles plus DONE; pending = silence.
- clear_stats together with a new timeout or underrun: the new event wins, so the bit is set or the count is 1.
- Reset asserted mid-gather: all outputs return to reset values immediately (asynchronous reset).
- Worst-case gather is NUM_SRC*(TIMEOUT+2)+2 cycles, well under the 1041-cycle sample period at the default parameters.

Optional Feature:
- Macro: AUDIO_MIX_VOLUME_EN.
- When defined:
  - Adds input port master_atten [2:0].
  - The saturated signed mix is arithmetically right-shifted by master_atten before MSB reconversion.
  - master_atten is sampled in DONE.
- When undefined: no port is added and the mix is passed unattenuated.

Test Plan:
- Reset then advance with no sources enabled → dac_left = dac_right = 0x800000; busy pulses; missed = 0.
- One gather with src_enable = 4'b0011, src0 L = 0x900000, src1 L = 0x900000, each acking 2 cycles after req → at the second advance dac_left = 0xA00000.
- Saturation: all 4 sources L = 0xF00000 → next-frame dac_left = 0xFFFFFF. All 4 L = 0x100000 → dac_left = 0x000000.
- Source 2 never acks, TIMEOUT = 64 → src_req[2] high exactly 64 cycles; missed = 4'b0100; mix excludes source 2; clear_stats clears the flag.
- Advance re-pulsed 20 cycles into a gather where sources ack slowly → dac_* = 0x800000; underrun_count = 1; src_req[0] reasserts after a one-cycle gap.
- With AUDIO_MIX_VOLUME_EN, master_atten = 1, single source L = 0xC00000 → dac_left = 0xA00000.
